// File: rtl/yuv2rgb_stream_converter.sv
// yuv2rgb_stream_converter: 3-stage BT.601 YUV->RGB stream converter; define YUV2RGB_ROUND_EN for round-half-up
module yuv2rgb_stream_converter #(
  parameter int PIX_W      = 8,
  parameter int COEF_W     = 20,
  parameter int FRAC       = 16,
  parameter int Y_OFS      = 16,
  parameter int C_OFS      = 128,
  parameter int NUM_PIXELS = 76800,
  parameter int CNT_W      = 17,
  parameter int K_RY       = 76284,
  parameter int K_RU       = 0,
  parameter int K_RV       = 104595,
  parameter int K_GY       = 76284,
  parameter int K_GU       = -25624,
  parameter int K_GV       = -53281,
  parameter int K_BY       = 76284,
  parameter int K_BU       = 132251,
  parameter int K_BV       = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [PIX_W-1:0]   s_y,
  input  logic [PIX_W-1:0]   s_u,
  input  logic [PIX_W-1:0]   s_v,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [3*PIX_W-1:0] m_rgb,
  output logic               m_last,
  output logic               frame_done
);
  localparam int D_W = PIX_W + 2;
  localparam int P_W = COEF_W + D_W;
  localparam int S_W = P_W + 2;
  localparam int MAXV = 2 ** PIX_W - 1;
  localparam int KC [9] = '{K_RY, K_RU, K_RV, K_GY, K_GU, K_GV, K_BY, K_BU, K_BV};
`ifdef YUV2RGB_ROUND_EN
  localparam logic signed [S_W-1:0] RND = S_W'(1 << (FRAC - 1));
`else
  localparam logic signed [S_W-1:0] RND = '0;
`endif
  logic adv, v1, v2;
  logic [CNT_W-1:0] cnt;
  logic signed [D_W-1:0] d [3];
  logic signed [P_W-1:0] prod [9];
  logic signed [P_W-1:0] p [9];
  logic [PIX_W-1:0] ch [3];
  assign adv = !m_valid || m_ready;
  assign s_ready = adv;
  assign m_last = m_valid && (cnt == CNT_W'(NUM_PIXELS - 1));
  for (genvar i = 0; i < 9; i++) begin : g_mul
    if (KC[i] == 0) begin : g_zero
      assign prod[i] = '0;
    end else begin : g_nz
      localparam logic signed [COEF_W-1:0] K = COEF_W'(KC[i]);
      assign prod[i] = P_W'(d[i % 3]) * P_W'(K);
    end
  end
  for (genvar r = 0; r < 3; r++) begin : g_row
    logic signed [S_W-1:0] sum, sh;
    assign sum = S_W'(p[3*r]) + S_W'(p[3*r+1]) + S_W'(p[3*r+2]) + RND;
    assign sh = sum >>> FRAC;
    assign ch[r] = sh[S_W-1] ? '0 : (sh > S_W'(MAXV)) ? '1 : sh[PIX_W-1:0];
  end
  // stage valids, frame counter and end-of-frame pulse
  always_ff @(posedge clk)
    if (rst || clr) begin
      v1         <= 1'b0;
      v2         <= 1'b0;
      m_valid    <= 1'b0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= m_valid && m_ready && m_last;
      if (m_valid && m_ready) cnt <= m_last ? '0 : cnt + 1'b1;
      if (adv) begin
        v1      <= s_valid;
        v2      <= v1;
        m_valid <= v2;
      end
    end
  // offset removal and product registers, held while the output stalls
  always_ff @(posedge clk) begin
    if (adv && s_valid) begin
      d[0] <= $signed({2'b00, s_y}) - D_W'(Y_OFS);
      d[1] <= $signed({2'b00, s_u}) - D_W'(C_OFS);
      d[2] <= $signed({2'b00, s_v}) - D_W'(C_OFS);
    end
    if (adv) p <= prod;
  end
  // saturated row results into the output register
  always_ff @(posedge clk)
    if (rst) m_rgb <= '0;
    else if (adv && v2) m_rgb <= {ch[0], ch[1], ch[2]};
endmodule
